two_digit_entry: RTL and testbench
==================================

Name: two_digit_entry

Overview:
- Sequential input-side counterpart to the binary-to-two-digit display path: collects up to two decimal digit entries (tens, then units) from the keypad front end.
- On enter, emits the binary value 0..99 to the calculator operand registers over a valid/ready handshake.
- Sits between the keypad scanner and the 8-bit ALU operand latch.

Parameters:
- OUT_W, 8, width of val_data; must be >= 7. Bits above 6 are always zero.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- dig_valid  input  1  digit strobe from keypad front end
- dig_ready  output  1  block can accept a digit this cycle
- dig_data  input  4 (7 with SEG_INPUT_EN)  BCD digit (segment pattern with SEG_INPUT_EN)
- enter  input  1  commit entered digits, single-cycle pulse
- clr  input  1  discard entry, single-cycle pulse
- val_valid  output  1  val_data holds a committed value
- val_ready  input  1  consumer accepts val_data
- val_data  output  OUT_W  committed binary value
- digit_cnt  output  2  digits currently held (0..2)
- err  output  1  one-cycle pulse on an invalid digit

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values:
  - State is IDLE.
  - val_valid=0, val_data=0, digit_cnt=0, err=0.
  - The tens and units registers are 0.
  - dig_ready=0 while rst is high.
- dig_ready is combinational from state: 1 in IDLE and D1, 0 in D2 and HOLD.
- A digit accept occurs when dig_valid && dig_ready.
- States and transitions:
  - IDLE: a valid digit accept stores units=d, tens=0, and moves to D1.
  - D1: a valid digit accept shifts tens=units, units=d, and moves to D2.
  - D2: dig_ready is 0, so further digits stall upstream without being dropped or overwriting.
  - HOLD: val_valid=1 and val_data stays stable until val_ready. The handshake moves to IDLE, clears tens, units and digit_cnt, and deasserts val_valid on the next cycle.
- Enter:
  - enter in IDLE, D1 or D2 moves to HOLD with val_data = tens*10 + units, computed as (tens<<3)+(tens<<1)+units.
  - enter in IDLE commits the value 0.
  - Latency: enter sampled in cycle N gives val_valid=1 in cycle N+1.
  - Enter is ignored in HOLD.
- Invalid digit (BCD > 9, or an unmatched pattern with SEG_INPUT_EN):
  - The digit is consumed, since the handshake completes.
  - No state or register change.
  - err=1 for exactly the next cycle.
- Simultaneous events:
  - Digit accept plus enter in the same cycle: the digit is stored first and is included in the committed value. For example, D1 holding 4 plus digit 2 plus enter commits 42.
  - clr has priority over enter and digit accept. In any state, clr goes to IDLE, clears registers and digit_cnt, and drops val_valid next cycle even if no handshake has occurred.
  - rst has priority over clr.
- digit_cnt is 0 in IDLE, 1 in D1 and 2 in D2. In HOLD it keeps its pre-enter value.
- val_data must not change while val_valid=1.

Optional Feature:
- Macro: SEG_INPUT_EN.
- Defined:
  - dig_data is 7 bits of active-low segments {a,b,c,d,e,f,g}, a in the MSB.
  - Patterns decode to digits as follows: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
  - Any other pattern is invalid and raises err.
- Undefined: dig_data is 4-bit BCD, and values 10..15 are invalid.

Decomposition:
- Shared package calc_pkg holds:
  - The state enum (IDLE, D1, D2, HOLD).
  - The digit-to-segment constants SEG_0..SEG_9, the same table used by the display decoders.
  - The BCD_MAX=9 constant.
- Sub-module seg7_to_digit (combinational, 7-bit in, 4-bit digit plus valid out) is instantiated only under SEG_INPUT_EN.

Test Plan:
- Reset, then digits 4 and 2, then enter → val_valid=1 one cycle after enter with val_data=8'd42. Hold val_ready low 3 cycles: val_data stays stable. Assert val_ready → IDLE, digit_cnt=0.
- Digits 9, 9 and a third digit 5 held valid → dig_ready=0 in D2 so 5 stalls. Then enter → val_data=8'd99.
- Digit 7 then BCD 4'hC → err pulses one cycle and digit_cnt stays 1. Enter → val_data=8'd7.
- Enter in IDLE → val_data=0, val_valid=1. Digit 3 then clr while in D1 → IDLE, digit_cnt=0. Clr in HOLD → val_valid drops next cycle.
- In D1 holding 6, digit 1 plus enter in the same cycle → val_data=8'd61. Rst asserted in HOLD → all outputs 0 next cycle.
- With SEG_INPUT_EN: patterns 0000110 then 0001100, then enter → val_data=8'd39. Pattern 1111111 → err pulse and no digit stored.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator digit entry path
// SEG_INPUT_EN selects the 7-bit segment-pattern digit input instead of 4-bit BCD.
package calc_pkg;

  typedef enum logic [1:0] {IDLE, D1, D2, HOLD} state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low segments {a,b,c,d,e,f,g}, shared with the display decoders
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;

`ifdef SEG_INPUT_EN
  localparam int DIG_W = 7;
`else
  localparam int DIG_W = 4;
`endif

endpackage

// File: rtl/seg7_to_digit.sv
// rtl/seg7_to_digit.sv - decodes an active-low segment pattern back to a digit
// Used only when SEG_INPUT_EN is defined; unknown patterns report valid_o=0.
module seg7_to_digit
  import calc_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       valid_o
);

  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/two_digit_entry.sv
// rtl/two_digit_entry.sv - collects tens/units digits and commits 0..99 over valid/ready
// SEG_INPUT_EN switches dig_data to 7-bit active-low segment patterns.
module two_digit_entry
  import calc_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic [DIG_W-1:0] dig_data,
  input  logic             enter,
  input  logic             clr,
  output logic             val_valid,
  input  logic             val_ready,
  output logic [OUT_W-1:0] val_data,
  output logic [1:0]       digit_cnt,
  output logic             err
);

  state_t           state_q;
  logic [3:0]       tens_q, units_q, tens_d, units_d;
  logic [1:0]       digit_cnt_q, digit_cnt_d;
  logic             val_valid_q, err_q;
  logic [OUT_W-1:0] val_data_q;
  logic [3:0]       digit;
  logic             digit_ok, accept, good_acc, bad_acc;
  logic [6:0]       value;

`ifdef SEG_INPUT_EN
  seg7_to_digit u_seg7_to_digit (
    .seg_i   (dig_data),
    .digit_o (digit),
    .valid_o (digit_ok)
  );
`else
  assign digit    = dig_data;
  assign digit_ok = (dig_data <= BCD_MAX);
`endif

  assign dig_ready = !rst && ((state_q == IDLE) || (state_q == D1));
  assign accept    = dig_valid && dig_ready;
  assign good_acc  = accept && digit_ok;
  assign bad_acc   = accept && !digit_ok;

  // Digit shift happens before the commit so digit+enter in one cycle includes the digit
  always_comb begin
    tens_d      = tens_q;
    units_d     = units_q;
    digit_cnt_d = digit_cnt_q;
    if (good_acc) begin
      tens_d      = (state_q == IDLE) ? 4'd0 : units_q;
      units_d     = digit;
      digit_cnt_d = digit_cnt_q + 2'd1;
    end
  end

  assign value = ({3'b000, tens_d} << 3) + ({3'b000, tens_d} << 1) + {3'b000, units_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      digit_cnt_q <= 2'd0;
      val_valid_q <= 1'b0;
      val_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      tens_q      <= 4'd0;
      units_q     <= 4'd0;
      digit_cnt_q <= 2'd0;
      val_valid_q <= 1'b0;
      val_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= bad_acc;
      case (state_q)
        IDLE, D1, D2: begin
          tens_q      <= tens_d;
          units_q     <= units_d;
          digit_cnt_q <= digit_cnt_d;
          if (enter) begin
            state_q     <= HOLD;
            val_valid_q <= 1'b1;
            val_data_q  <= OUT_W'(value);
          end else if (good_acc) begin
            state_q <= (state_q == IDLE) ? D1 : D2;
          end
        end
        HOLD: begin
          if (val_ready) begin
            state_q     <= IDLE;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            digit_cnt_q <= 2'd0;
            val_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign val_valid = val_valid_q;
  assign val_data  = val_data_q;
  assign digit_cnt = digit_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_two_digit_entry.sv
// tb/tb_two_digit_entry.sv - directed self-checking bench for two_digit_entry
// Covers the BCD build; the segment-pattern vectors run when SEG_INPUT_EN is defined.
module tb_two_digit_entry;

`ifdef SEG_INPUT_EN
  localparam int DW = 7;
`else
  localparam int DW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst, dig_valid, enter, clr, val_ready;
  logic [DW-1:0] dig_data;
  logic          dig_ready, val_valid, err;
  logic [7:0]    val_data;
  logic [1:0]    digit_cnt;
  int            total = 0;
  int            bad = 0;

  two_digit_entry #(.OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .dig_data  (dig_data),
    .enter     (enter),
    .clr       (clr),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .val_data  (val_data),
    .digit_cnt (digit_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] enc(input int d);
`ifdef SEG_INPUT_EN
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0001100;
      default: return 7'b1111111;
    endcase
`else
    return DW'(d);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_digit(input int d);
    dig_valid = 1'b1;
    dig_data  = enc(d);
    step();
    dig_valid = 1'b0;
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic handshake();
    val_ready = 1'b1;
    step();
    val_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dig_valid = 1'b0; dig_data = '0; enter = 1'b0; clr = 1'b0; val_ready = 1'b0;
    step();
    step();
    chk("rst_dig_ready", 32'(dig_ready), 0);
    chk("rst_val_valid", 32'(val_valid), 0);
    chk("rst_val_data", 32'(val_data), 0);
    chk("rst_digit_cnt", 32'(digit_cnt), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    #1;
    chk("idle_dig_ready", 32'(dig_ready), 1);

    // 4, 2, enter -> 42 held until val_ready
    send_digit(4);
    chk("cnt_after_4", 32'(digit_cnt), 1);
    send_digit(2);
    chk("cnt_after_42", 32'(digit_cnt), 2);
    chk("d2_dig_ready", 32'(dig_ready), 0);
    pulse_enter();
    chk("v42_valid", 32'(val_valid), 1);
    chk("v42_data", 32'(val_data), 42);
    chk("hold_cnt", 32'(digit_cnt), 2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("v42_stable", 32'(val_data), 42);
      chk("v42_still_valid", 32'(val_valid), 1);
    end
    handshake();
    chk("hs_val_valid", 32'(val_valid), 0);
    chk("hs_digit_cnt", 32'(digit_cnt), 0);
    chk("hs_dig_ready", 32'(dig_ready), 1);

    // 9, 9, then a stalled 5 -> 99
    send_digit(9);
    send_digit(9);
    dig_valid = 1'b1;
    dig_data  = enc(5);
    step();
    chk("stall_cnt", 32'(digit_cnt), 2);
    chk("stall_ready", 32'(dig_ready), 0);
    step();
    chk("stall_cnt2", 32'(digit_cnt), 2);
    pulse_enter();
    dig_valid = 1'b0;
    chk("v99_data", 32'(val_data), 99);
    chk("v99_valid", 32'(val_valid), 1);
    handshake();

    // 7 then invalid BCD -> err pulse, value stays 7
    send_digit(7);
    dig_valid = 1'b1;
    dig_data  = DW'(12);
`ifdef SEG_INPUT_EN
    dig_data  = 7'b1111111;
`endif
    step();
    dig_valid = 1'b0;
    chk("bad_err", 32'(err), 1);
    chk("bad_cnt", 32'(digit_cnt), 1);
    step();
    chk("bad_err_drop", 32'(err), 0);
    pulse_enter();
    chk("v7_data", 32'(val_data), 7);
    handshake();

    // enter in IDLE commits 0
    pulse_enter();
    chk("v0_valid", 32'(val_valid), 1);
    chk("v0_data", 32'(val_data), 0);
    handshake();

    // clr in D1 and clr in HOLD
    send_digit(3);
    chk("d1_cnt", 32'(digit_cnt), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_d1_cnt", 32'(digit_cnt), 0);
    chk("clr_d1_ready", 32'(dig_ready), 1);
    pulse_enter();
    chk("clr_hold_pre", 32'(val_valid), 1);
    chk("clr_units_cleared", 32'(val_data), 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_hold_valid", 32'(val_valid), 0);

    // 6 then digit 1 with enter in the same cycle -> 61
    send_digit(6);
    dig_valid = 1'b1;
    dig_data  = enc(1);
    enter     = 1'b1;
    step();
    dig_valid = 1'b0;
    enter     = 1'b0;
    chk("v61_data", 32'(val_data), 61);
    chk("v61_valid", 32'(val_valid), 1);

    // rst in HOLD
    rst = 1'b1;
    step();
    chk("rst_hold_valid", 32'(val_valid), 0);
    chk("rst_hold_data", 32'(val_data), 0);
    chk("rst_hold_cnt", 32'(digit_cnt), 0);
    chk("rst_hold_ready", 32'(dig_ready), 0);
    rst = 1'b0;
    pulse_enter();
    chk("rst_regs_cleared", 32'(val_data), 0);
    handshake();

    // two-digit commit after idle restart: 5 then 8 -> 58
    send_digit(5);
    send_digit(8);
    pulse_enter();
    chk("v58_data", 32'(val_data), 58);
    handshake();

`ifdef SEG_INPUT_EN
    dig_valid = 1'b1;
    dig_data  = 7'b0000110;
    step();
    dig_data  = 7'b0001100;
    step();
    dig_valid = 1'b0;
    pulse_enter();
    chk("seg39_data", 32'(val_data), 39);
    handshake();
    dig_valid = 1'b1;
    dig_data  = 7'b1111111;
    step();
    dig_valid = 1'b0;
    chk("seg_bad_err", 32'(err), 1);
    chk("seg_bad_cnt", 32'(digit_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
